// File: rtl/stream_wb_responder.sv
// stream_wb_responder
// Consumer end of a valid/ready request stream. Each accepted request becomes one
// Wishbone classic single-beat cycle; the outcome (read data, bus error or timeout)
// is returned on a valid/ready response stream. Only one transaction is in flight.
module stream_wb_responder #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [AW-1:0]   req_addr_i,
   input  logic [DW-1:0]   req_wdata_i,
   input  logic [DW/8-1:0] req_sel_i,
   input  logic            req_we_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_rdata_o,
   output logic            rsp_err_o,
   output logic            rsp_tmo_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i
);

   localparam int SW = DW / 8;
   // Counter only has to reach TIMEOUT; keep at least one bit when the timeout is disabled.
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   // Count value seen during the TIMEOUT-th BUS cycle (count increments after that cycle).
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            tmo_hit;
   logic            wb_cyc_q;
   logic            wb_we_q;
   logic [AW-1:0]   wb_adr_q;
   logic [DW-1:0]   wb_dat_q;
   logic [SW-1:0]   wb_sel_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic            rsp_err_q;
   logic            rsp_tmo_q;

   // Saturating next count and the timeout condition for the current BUS cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '1) begin
         cnt_d = cnt_q + CW'(1);
      end
      tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
   end

   // Transaction FSM: request capture, bus cycle termination and response hold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wb_cyc_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_adr_q    <= '0;
         wb_dat_q    <= '0;
         wb_sel_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
      end else if (clr_i) begin
         // Abort: drop whatever is in flight without producing a response.
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wb_cyc_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  wb_adr_q <= req_addr_i;
                  wb_dat_q <= req_wdata_i;
                  wb_sel_q <= req_sel_i;
                  wb_we_q  <= req_we_i;
                  wb_cyc_q <= 1'b1;
                  state_q  <= S_BUS;
               end
            end
            S_BUS: begin
               cnt_q <= cnt_d;
               if (wb_err_i || wb_ack_i || tmo_hit) begin
                  // err beats ack; any slave response beats the timeout.
                  rsp_err_q   <= wb_err_i || !wb_ack_i;
                  rsp_tmo_q   <= !wb_err_i && !wb_ack_i;
                  rsp_rdata_q <= (wb_ack_i && !wb_err_i && !wb_we_q) ? wb_dat_i : '0;
                  wb_cyc_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign wb_cyc_o    = wb_cyc_q;
   assign wb_stb_o    = wb_cyc_q;
   assign wb_we_o     = wb_we_q;
   assign wb_adr_o    = wb_adr_q;
   assign wb_dat_o    = wb_dat_q;
   assign wb_sel_o    = wb_sel_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_tmo_o   = rsp_tmo_q;

endmodule

// File: tb/tb_stream_wb_responder.sv
// Testbench for stream_wb_responder: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_stream_wb_responder;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_sel = '0;
   logic        req_we = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_tmo;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dat_s = '0;
   logic        wb_ack = 1'b0;
   logic        wb_err = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic cmp_en = 1'b0;

   stream_wb_responder #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel), .req_we_i(req_we),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_s),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // m_busy: a request owns the bus; m_hold: a response waits for the consumer.
   logic        m_busy, m_hold, m_we, m_err, m_tmo;
   int          m_n;
   logic [31:0] m_adr, m_dat, m_rd;
   logic [3:0]  m_sel;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_hold <= 1'b0; m_n <= 0;
         m_adr <= '0; m_dat <= '0; m_sel <= '0; m_we <= 1'b0;
         m_rd <= '0; m_err <= 1'b0; m_tmo <= 1'b0;
      end else if (clr) begin
         m_busy <= 1'b0;
         m_hold <= 1'b0;
      end else if (m_hold) begin
         if (rsp_ready) m_hold <= 1'b0;
      end else if (m_busy) begin
         m_n <= m_n + 1;
         if (wb_err || wb_ack || (m_n + 1 == TMO)) begin
            m_busy <= 1'b0;
            m_hold <= 1'b1;
            m_err  <= wb_err || !wb_ack;
            m_tmo  <= !wb_err && !wb_ack;
            m_rd   <= (wb_ack && !wb_err && !m_we) ? wb_dat_s : 32'h0;
         end
      end else if (req_valid) begin
         m_busy <= 1'b1; m_n <= 0;
         m_adr <= req_addr; m_dat <= req_wdata; m_sel <= req_sel; m_we <= req_we;
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_req_ready", 32'(req_ready), 32'(!m_busy && !m_hold));
         check("m_cyc", 32'(wb_cyc), 32'(m_busy));
         check("m_stb", 32'(wb_stb), 32'(m_busy));
         check("m_rsp_valid", 32'(rsp_valid), 32'(m_hold));
         if (m_busy) begin
            check("m_wb_adr", wb_adr, m_adr);
            check("m_wb_dat", wb_dat_o, m_dat);
            check("m_wb_sel", 32'(wb_sel), 32'(m_sel));
            check("m_wb_we", 32'(wb_we), 32'(m_we));
         end
         if (m_hold) begin
            check("m_rsp_rdata", rsp_rdata, m_rd);
            check("m_rsp_err", 32'(rsp_err), 32'(m_err));
            check("m_rsp_tmo", 32'(rsp_tmo), 32'(m_tmo));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; the slave answers with {ack,err} in BUS cycle resp_at (0 = never).
   // Returns the number of cycles the bus cycle was observed active.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                          input logic w, input int resp_at, input logic ra, input logic re,
                          input logic [31:0] sd, output int ncyc);
      ncyc = 0;
      req_valid = 1'b1; req_addr = a; req_wdata = wd; req_sel = s; req_we = w;
      step();
      req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (!wb_cyc) break;
         ncyc++;
         wb_ack = (k == resp_at) && ra;
         wb_err = (k == resp_at) && re;
         wb_dat_s = sd;
         step();
      end
      wb_ack = 1'b0; wb_err = 1'b0;
      if (wb_cyc) check("bus_bound", 32'(wb_cyc), 32'd0);
   endtask

   task automatic finish_rsp(input int stall);
      rsp_ready = 1'b0;
      for (int i = 0; i < stall; i++) step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   int n;

   initial begin
      // Reset
      rst_n = 1'b0;
      step(); step();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_cyc", 32'(wb_cyc), 32'd0);
      rst_n = 1'b1;
      step();
      cmp_en = 1'b1;
      check("rst_stb", 32'(wb_stb), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wb_adr", wb_adr, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);

      // Read, ack in first BUS cycle
      run_txn(32'h10, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'hDEADBEEF, n);
      check("rd_cyc_len", 32'(n), 32'd1);
      check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
      check("rd_err", 32'(rsp_err), 32'd0);
      check("rd_req_ready_resp", 32'(req_ready), 32'd0);
      finish_rsp(0);
      check("rd_req_ready_back", 32'(req_ready), 32'd1);
      check("rd_rsp_valid_low", 32'(rsp_valid), 32'd0);

      // Write with 4 wait states
      run_txn(32'h20, 32'h12345678, 4'hC, 1'b1, 5, 1'b1, 1'b0, 32'hFFFF0000, n);
      check("wr_cyc_len", 32'(n), 32'd5);
      check("wr_rdata", rsp_rdata, 32'h0);
      check("wr_err", 32'(rsp_err), 32'd0);
      finish_rsp(0);

      // ack and err together
      run_txn(32'h30, 32'h0, 4'hF, 1'b0, 2, 1'b1, 1'b1, 32'hA5A5A5A5, n);
      check("ae_cyc_len", 32'(n), 32'd2);
      check("ae_err", 32'(rsp_err), 32'd1);
      check("ae_tmo", 32'(rsp_tmo), 32'd0);
      check("ae_rdata", rsp_rdata, 32'h0);
      finish_rsp(0);

      // Timeout with silent slave, then a late ack that must be ignored
      run_txn(32'h40, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b0, 32'h11112222, n);
      check("to_cyc_len", 32'(n), 32'd8);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_tmo", 32'(rsp_tmo), 32'd1);
      check("to_rdata", rsp_rdata, 32'h0);
      wb_ack = 1'b1;
      step(); step();
      wb_ack = 1'b0;
      check("late_ack_cyc", 32'(wb_cyc), 32'd0);
      check("late_ack_tmo", 32'(rsp_tmo), 32'd1);
      check("late_ack_valid", 32'(rsp_valid), 32'd1);
      finish_rsp(0);

      // Ack in the TIMEOUT-th cycle wins over the timeout
      run_txn(32'h44, 32'h0, 4'h3, 1'b0, 8, 1'b1, 1'b0, 32'hCAFEF00D, n);
      check("edge_cyc_len", 32'(n), 32'd8);
      check("edge_err", 32'(rsp_err), 32'd0);
      check("edge_tmo", 32'(rsp_tmo), 32'd0);
      check("edge_rdata", rsp_rdata, 32'hCAFEF00D);
      finish_rsp(0);

      // Response backpressure for 6 cycles
      run_txn(32'h50, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'h0BADC0DE, n);
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rdata", rsp_rdata, 32'h0BADC0DE);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("bp_idle", 32'(req_ready), 32'd1);
      check("bp_valid_low", 32'(rsp_valid), 32'd0);

      // clr during BUS
      req_valid = 1'b1; req_addr = 32'h60; req_wdata = 32'h0; req_sel = 4'hF; req_we = 1'b0;
      step();
      req_valid = 1'b0;
      check("clr_cyc_before", 32'(wb_cyc), 32'd1);
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_cyc", 32'(wb_cyc), 32'd0);
      check("clr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("clr_req_ready", 32'(req_ready), 32'd1);
      step();
      check("clr_no_rsp", 32'(rsp_valid), 32'd0);
      run_txn(32'h64, 32'h0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 32'h5A5A1234, n);
      check("clr_next_rdata", rsp_rdata, 32'h5A5A1234);
      finish_rsp(0);

      // Asynchronous reset while in RESP
      run_txn(32'h70, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'h77777777, n);
      check("ar_rsp_valid_before", 32'(rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      check("ar_cyc", 32'(wb_cyc), 32'd0);
      check("ar_req_ready", 32'(req_ready), 32'd1);
      check("ar_rdata", rsp_rdata, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      run_txn(32'h74, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'h89ABCDEF, n);
      check("ar_next_rdata", rsp_rdata, 32'h89ABCDEF);
      finish_rsp(0);
      step();

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
